// File: rtl/gate_boy_pkg.sv
// Shared types and constants for the gate_boy CPU datapath.
// Flag bit positions follow the {Z,N,H,C} ordering used on every flag bus.
package gate_boy_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned FLAG_WIDTH = 4;

    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_N = 2;
    localparam int unsigned FLAG_H = 1;
    localparam int unsigned FLAG_C = 0;

    typedef enum logic [1:0] {
        IDU_INC  = 2'd0,
        IDU_DEC  = 2'd1,
        IDU_PASS = 2'd2
    } idu_op_t;

    typedef enum logic [2:0] {
        PAIR_BC = 3'd0,
        PAIR_DE = 3'd1,
        PAIR_HL = 3'd2,
        PAIR_SP = 3'd3,
        PAIR_PC = 3'd4
    } pair_t;

    typedef enum logic [2:0] {
        REG_B = 3'd0,
        REG_C = 3'd1,
        REG_D = 3'd2,
        REG_E = 3'd3,
        REG_H = 3'd4,
        REG_L = 3'd5,
        REG_F = 3'd6,
        REG_A = 3'd7
    } reg_sel_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file access bundle between the CPU control path (master) and reg_file (slave).
interface reg_file_if;
    import gate_boy_pkg::*;

    logic [2:0]            rd_sel_a;
    logic [2:0]            rd_sel_b;
    logic [DATA_WIDTH-1:0] operand_A;
    logic [DATA_WIDTH-1:0] operand_B;

    logic                  wr_en;
    logic [2:0]            wr_sel;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [FLAG_WIDTH-1:0] flags_we;
    logic [FLAG_WIDTH-1:0] flags_in;
    logic [FLAG_WIDTH-1:0] flags;

    logic                  idu_en;
    idu_op_t               idu_op;
    pair_t                 idu_sel;
    logic [15:0]           idu_result;

    logic                  pair_we;
    pair_t                 pair_sel;
    logic [15:0]           pair_wdata;
    pair_t                 pair_rd_sel;
    logic [15:0]           pair_rdata;

    logic [15:0]           pc;
    logic [15:0]           sp;

    modport master (
        output rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data, flags_we, flags_in,
               idu_en, idu_op, idu_sel, pair_we, pair_sel, pair_wdata, pair_rd_sel,
        input  operand_A, operand_B, flags, idu_result, pair_rdata, pc, sp
    );

    modport slave (
        input  rd_sel_a, rd_sel_b, wr_en, wr_sel, wr_data, flags_we, flags_in,
               idu_en, idu_op, idu_sel, pair_we, pair_sel, pair_wdata, pair_rd_sel,
        output operand_A, operand_B, flags, idu_result, pair_rdata, pc, sp
    );

endinterface

// File: rtl/reg_file_idu.sv
// 16-bit increment/decrement unit; purely combinational, wraps modulo 2^16.
module idu
    import gate_boy_pkg::*;
(
    input  logic [15:0] val_i,
    input  idu_op_t     op_i,
    output logic [15:0] result_o
);

    always_comb begin
        result_o = val_i;
        case (op_i)
            IDU_INC: result_o = val_i + 16'd1;
            IDU_DEC: result_o = val_i - 16'd1;
            default: result_o = val_i;
        endcase
    end

endmodule

// File: rtl/reg_file.sv
// SM83-style register file: byte registers, flags, SP/PC, and an IDU for pair updates.
// Reads are from registered state only; all writes commit on the next rising edge.
module reg_file
    import gate_boy_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0100,
    parameter logic [15:0] RESET_SP = 16'hFFFE
) (
    input logic       clk,
    input logic       rst_n,
    reg_file_if.slave rf
);

    logic [7:0]            b_q, c_q, d_q, e_q, h_q, l_q, a_q;
    logic [7:0]            b_d, c_d, d_d, e_d, h_d, l_d, a_d;
    logic [FLAG_WIDTH-1:0] flags_q, flags_d;
    logic [15:0]           pc_q, pc_d;
    logic [15:0]           sp_q, sp_d;

    logic [7:0]            rd_view [8];
    logic [15:0]           idu_src;
    logic [15:0]           idu_res;

    // F's low nibble does not exist in hardware and always reads as zero.
    always_comb begin
        rd_view[0] = b_q;
        rd_view[1] = c_q;
        rd_view[2] = d_q;
        rd_view[3] = e_q;
        rd_view[4] = h_q;
        rd_view[5] = l_q;
        rd_view[6] = {flags_q, 4'b0000};
        rd_view[7] = a_q;
    end

    assign rf.operand_A = rd_view[rf.rd_sel_a];
    assign rf.operand_B = rd_view[rf.rd_sel_b];
    assign rf.flags     = flags_q;
    assign rf.pc        = pc_q;
    assign rf.sp        = sp_q;

    always_comb begin
        rf.pair_rdata = '0;
        case (rf.pair_rd_sel)
            PAIR_BC: rf.pair_rdata = {b_q, c_q};
            PAIR_DE: rf.pair_rdata = {d_q, e_q};
            PAIR_HL: rf.pair_rdata = {h_q, l_q};
            PAIR_SP: rf.pair_rdata = sp_q;
            PAIR_PC: rf.pair_rdata = pc_q;
            default: rf.pair_rdata = '0;
        endcase
    end

    always_comb begin
        idu_src = '0;
        case (rf.idu_sel)
            PAIR_BC: idu_src = {b_q, c_q};
            PAIR_DE: idu_src = {d_q, e_q};
            PAIR_HL: idu_src = {h_q, l_q};
            PAIR_SP: idu_src = sp_q;
            PAIR_PC: idu_src = pc_q;
            default: idu_src = '0;
        endcase
    end

    idu u_idu (
        .val_i    (idu_src),
        .op_i     (rf.idu_op),
        .result_o (idu_res)
    );

    assign rf.idu_result = idu_res;

    // Writers are applied lowest priority first so later ones win per byte:
    // wr_en < idu_en < pair_we, and for F: flags_we < wr_en index 6.
    always_comb begin
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        e_d     = e_q;
        h_d     = h_q;
        l_d     = l_q;
        a_d     = a_q;
        flags_d = flags_q;
        pc_d    = pc_q;
        sp_d    = sp_q;

        for (int unsigned i = 0; i < FLAG_WIDTH; i++) begin
            if (rf.flags_we[i]) flags_d[i] = rf.flags_in[i];
        end

        if (rf.wr_en) begin
            case (reg_sel_t'(rf.wr_sel))
                REG_B:   b_d     = rf.wr_data;
                REG_C:   c_d     = rf.wr_data;
                REG_D:   d_d     = rf.wr_data;
                REG_E:   e_d     = rf.wr_data;
                REG_H:   h_d     = rf.wr_data;
                REG_L:   l_d     = rf.wr_data;
                REG_F:   flags_d = rf.wr_data[7:4];
                default: a_d     = rf.wr_data;
            endcase
        end

        if (rf.idu_en) begin
            case (rf.idu_sel)
                PAIR_BC: {b_d, c_d} = idu_res;
                PAIR_DE: {d_d, e_d} = idu_res;
                PAIR_HL: {h_d, l_d} = idu_res;
                PAIR_SP: sp_d       = idu_res;
                PAIR_PC: pc_d       = idu_res;
                default: ;
            endcase
        end

        if (rf.pair_we) begin
            case (rf.pair_sel)
                PAIR_BC: {b_d, c_d} = rf.pair_wdata;
                PAIR_DE: {d_d, e_d} = rf.pair_wdata;
                PAIR_HL: {h_d, l_d} = rf.pair_wdata;
                PAIR_SP: sp_d       = rf.pair_wdata;
                PAIR_PC: pc_d       = rf.pair_wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            h_q     <= '0;
            l_q     <= '0;
            a_q     <= '0;
            flags_q <= '0;
            pc_q    <= RESET_PC;
            sp_q    <= RESET_SP;
        end else begin
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            e_q     <= e_d;
            h_q     <= h_d;
            l_q     <= l_d;
            a_q     <= a_d;
            flags_q <= flags_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic
// checked against an architectural model of the register file.
module tb_reg_file;
    import gate_boy_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    reg_file_if rf_if ();

    reg_file #(
        .RESET_PC (16'h0100),
        .RESET_SP (16'hFFFE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rf    (rf_if)
    );

    // Architectural model: index 0..7 = B,C,D,E,H,L,(unused),A
    logic [7:0]  m_r [8];
    logic [3:0]  m_flags;
    logic [15:0] m_pc, m_sp;

    function automatic logic [7:0] m_read(input int idx);
        return (idx == 6) ? {m_flags, 4'h0} : m_r[idx];
    endfunction

    function automatic logic [15:0] m_pair(input int p);
        case (p)
            0: return {m_r[0], m_r[1]};
            1: return {m_r[2], m_r[3]};
            2: return {m_r[4], m_r[5]};
            3: return m_sp;
            4: return m_pc;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic [15:0] m_idu(input logic [15:0] v, input int op);
        int unsigned r;
        r = (op == 0) ? (int'(v) + 1) % 65536 :
            (op == 1) ? (int'(v) + 65535) % 65536 : int'(v);
        return r[15:0];
    endfunction

    task automatic m_set_pair(input int p, input logic [15:0] v);
        case (p)
            0: begin m_r[0] = v[15:8]; m_r[1] = v[7:0]; end
            1: begin m_r[2] = v[15:8]; m_r[3] = v[7:0]; end
            2: begin m_r[4] = v[15:8]; m_r[5] = v[7:0]; end
            3: m_sp = v;
            4: m_pc = v;
            default: ;
        endcase
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = 8'h00;
        m_flags = 4'h0;
        m_pc = 16'h0100;
        m_sp = 16'hFFFE;
    endtask

    // Called just after a rising edge; inputs are still those seen by the edge.
    task automatic model_commit();
        logic [15:0] idu_val;
        logic [3:0]  new_flags;
        idu_val   = m_idu(m_pair(int'(rf_if.idu_sel)), int'(rf_if.idu_op));
        new_flags = (m_flags & ~rf_if.flags_we) | (rf_if.flags_in & rf_if.flags_we);
        if (rf_if.wr_en) begin
            if (rf_if.wr_sel == 3'd6) new_flags = rf_if.wr_data[7:4];
            else m_r[rf_if.wr_sel] = rf_if.wr_data;
        end
        m_flags = new_flags;
        if (rf_if.idu_en) m_set_pair(int'(rf_if.idu_sel), idu_val);
        if (rf_if.pair_we) m_set_pair(int'(rf_if.pair_sel), rf_if.pair_wdata);
    endtask

    task automatic drive_idle();
        rf_if.rd_sel_a    = 3'd0;
        rf_if.rd_sel_b    = 3'd0;
        rf_if.wr_en       = 1'b0;
        rf_if.wr_sel      = 3'd0;
        rf_if.wr_data     = 8'h00;
        rf_if.flags_we    = 4'h0;
        rf_if.flags_in    = 4'h0;
        rf_if.idu_en      = 1'b0;
        rf_if.idu_op      = IDU_PASS;
        rf_if.idu_sel     = PAIR_BC;
        rf_if.pair_we     = 1'b0;
        rf_if.pair_sel    = PAIR_BC;
        rf_if.pair_wdata  = 16'h0000;
        rf_if.pair_rd_sel = PAIR_BC;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_commit();
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        for (int i = 0; i < 8; i++) begin
            rf_if.rd_sel_a = i[2:0];
            rf_if.rd_sel_b = 3'(7 - i);
            #1;
            n_tests += 2;
            if (rf_if.operand_A !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_opA[%0d] got %h want 00", i, rf_if.operand_A);
            end
            if (rf_if.operand_B !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_opB[%0d] got %h want 00", 7 - i, rf_if.operand_B);
            end
        end
        n_tests += 3;
        if (rf_if.flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %h want 0", rf_if.flags); end
        if (rf_if.pc !== 16'h0100) begin n_fail++; $display("FAIL reset_pc got %h want 0100", rf_if.pc); end
        if (rf_if.sp !== 16'hFFFE) begin n_fail++; $display("FAIL reset_sp got %h want fffe", rf_if.sp); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_idle();
    endtask

    task automatic test_write_latency();
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd7; rf_if.wr_data = 8'h3C; rf_if.rd_sel_a = 3'd7;
        #1;
        n_tests++;
        if (rf_if.operand_A !== 8'h00) begin n_fail++; $display("FAIL same_cycle_read got %h want 00", rf_if.operand_A); end
        clock_edge();
        rf_if.rd_sel_a = 3'd7;
        #1;
        n_tests++;
        if (rf_if.operand_A !== 8'h3C) begin n_fail++; $display("FAIL write_latency got %h want 3c", rf_if.operand_A); end
    endtask

    task automatic test_flags();
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd6; rf_if.wr_data = 8'hFF;
        clock_edge();
        rf_if.rd_sel_b = 3'd6;
        #1;
        n_tests += 2;
        if (rf_if.operand_B !== 8'hF0) begin n_fail++; $display("FAIL f_index_read got %h want f0", rf_if.operand_B); end
        if (rf_if.flags !== 4'hF) begin n_fail++; $display("FAIL f_index_write got %h want f", rf_if.flags); end
        rf_if.flags_we = 4'b0001; rf_if.flags_in = 4'h0;
        clock_edge();
        #1;
        n_tests++;
        if (rf_if.flags !== 4'hE) begin n_fail++; $display("FAIL flags_we_c got %h want e", rf_if.flags); end
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd6; rf_if.wr_data = 8'h5A;
        rf_if.flags_we = 4'hF; rf_if.flags_in = 4'hA;
        clock_edge();
        #1;
        n_tests++;
        if (rf_if.flags !== 4'h5) begin n_fail++; $display("FAIL f_write_over_flags_we got %h want 5", rf_if.flags); end
    endtask

    task automatic test_idu_wrap();
        rf_if.pair_we = 1'b1; rf_if.pair_sel = PAIR_HL; rf_if.pair_wdata = 16'hFFFF;
        clock_edge();
        rf_if.idu_en = 1'b1; rf_if.idu_op = IDU_INC; rf_if.idu_sel = PAIR_HL; rf_if.pair_rd_sel = PAIR_HL;
        #1;
        n_tests += 2;
        if (rf_if.idu_result !== 16'h0000) begin n_fail++; $display("FAIL idu_inc_comb got %h want 0000", rf_if.idu_result); end
        if (rf_if.pair_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL hl_before_commit got %h want ffff", rf_if.pair_rdata); end
        clock_edge();
        rf_if.pair_rd_sel = PAIR_HL;
        #1;
        n_tests++;
        if (rf_if.pair_rdata !== 16'h0000) begin n_fail++; $display("FAIL hl_inc_wrap got %h want 0000", rf_if.pair_rdata); end
        rf_if.pair_we = 1'b1; rf_if.pair_sel = PAIR_SP; rf_if.pair_wdata = 16'h0000;
        clock_edge();
        rf_if.idu_en = 1'b1; rf_if.idu_op = IDU_DEC; rf_if.idu_sel = PAIR_SP;
        clock_edge();
        #1;
        n_tests++;
        if (rf_if.sp !== 16'hFFFF) begin n_fail++; $display("FAIL sp_dec_wrap got %h want ffff", rf_if.sp); end
    endtask

    task automatic test_priority();
        rf_if.pair_we = 1'b1; rf_if.pair_sel = PAIR_BC; rf_if.pair_wdata = 16'h1234;
        rf_if.idu_en = 1'b1; rf_if.idu_op = IDU_INC; rf_if.idu_sel = PAIR_BC;
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd1; rf_if.wr_data = 8'hAA;
        clock_edge();
        rf_if.pair_rd_sel = PAIR_BC;
        #1;
        n_tests++;
        if (rf_if.pair_rdata !== 16'h1234) begin n_fail++; $display("FAIL bc_priority got %h want 1234", rf_if.pair_rdata); end
        // Disjoint writers plus a byte merge into H: L must keep its value.
        rf_if.pair_we = 1'b1; rf_if.pair_sel = PAIR_DE; rf_if.pair_wdata = 16'hBEEF;
        rf_if.idu_en = 1'b1; rf_if.idu_op = IDU_INC; rf_if.idu_sel = PAIR_PC;
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd4; rf_if.wr_data = 8'h77;
        clock_edge();
        rf_if.pair_rd_sel = PAIR_DE;
        rf_if.rd_sel_a = 3'd4; rf_if.rd_sel_b = 3'd5;
        #1;
        n_tests += 4;
        if (rf_if.pair_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL disjoint_de got %h want beef", rf_if.pair_rdata); end
        if (rf_if.pc !== 16'h0101) begin n_fail++; $display("FAIL disjoint_pc got %h want 0101", rf_if.pc); end
        if (rf_if.operand_A !== 8'h77) begin n_fail++; $display("FAIL merge_h got %h want 77", rf_if.operand_A); end
        if (rf_if.operand_B !== 8'h00) begin n_fail++; $display("FAIL merge_l_kept got %h want 00", rf_if.operand_B); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rf_if.rd_sel_a    = 3'($urandom_range(7));
            rf_if.rd_sel_b    = 3'($urandom_range(7));
            rf_if.wr_en       = ($urandom_range(99) < 50);
            rf_if.wr_sel      = 3'($urandom_range(7));
            rf_if.wr_data     = 8'($urandom);
            rf_if.flags_we    = 4'($urandom);
            rf_if.flags_in    = 4'($urandom);
            rf_if.idu_en      = ($urandom_range(99) < 40);
            rf_if.idu_op      = idu_op_t'($urandom_range(2));
            rf_if.idu_sel     = pair_t'($urandom_range(4));
            rf_if.pair_we     = ($urandom_range(99) < 30);
            rf_if.pair_sel    = pair_t'($urandom_range(4));
            rf_if.pair_wdata  = ($urandom_range(9) == 0) ? 16'hFFFF : 16'($urandom);
            rf_if.pair_rd_sel = pair_t'($urandom_range(4));
            #1;
            n_tests += 7;
            if (rf_if.operand_A !== m_read(int'(rf_if.rd_sel_a))) begin
                n_fail++; $display("FAIL rnd_opA cyc %0d got %h want %h", n, rf_if.operand_A, m_read(int'(rf_if.rd_sel_a)));
            end
            if (rf_if.operand_B !== m_read(int'(rf_if.rd_sel_b))) begin
                n_fail++; $display("FAIL rnd_opB cyc %0d got %h want %h", n, rf_if.operand_B, m_read(int'(rf_if.rd_sel_b)));
            end
            if (rf_if.flags !== m_flags) begin
                n_fail++; $display("FAIL rnd_flags cyc %0d got %h want %h", n, rf_if.flags, m_flags);
            end
            if (rf_if.pair_rdata !== m_pair(int'(rf_if.pair_rd_sel))) begin
                n_fail++; $display("FAIL rnd_pair cyc %0d got %h want %h", n, rf_if.pair_rdata, m_pair(int'(rf_if.pair_rd_sel)));
            end
            if (rf_if.pc !== m_pc) begin
                n_fail++; $display("FAIL rnd_pc cyc %0d got %h want %h", n, rf_if.pc, m_pc);
            end
            if (rf_if.sp !== m_sp) begin
                n_fail++; $display("FAIL rnd_sp cyc %0d got %h want %h", n, rf_if.sp, m_sp);
            end
            if (rf_if.idu_result !== m_idu(m_pair(int'(rf_if.idu_sel)), int'(rf_if.idu_op))) begin
                n_fail++; $display("FAIL rnd_idu cyc %0d got %h want %h", n, rf_if.idu_result,
                                   m_idu(m_pair(int'(rf_if.idu_sel)), int'(rf_if.idu_op)));
            end
            clock_edge();
        end
    endtask

    task automatic test_async_reset();
        rf_if.wr_en = 1'b1; rf_if.wr_sel = 3'd7; rf_if.wr_data = 8'h99;
        rf_if.pair_we = 1'b1; rf_if.pair_sel = PAIR_PC; rf_if.pair_wdata = 16'h1234;
        rf_if.flags_we = 4'hF; rf_if.flags_in = 4'hF;
        rf_if.rd_sel_a = 3'd7;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_tests += 4;
        if (rf_if.pc !== 16'h0100) begin n_fail++; $display("FAIL async_rst_pc got %h want 0100", rf_if.pc); end
        if (rf_if.sp !== 16'hFFFE) begin n_fail++; $display("FAIL async_rst_sp got %h want fffe", rf_if.sp); end
        if (rf_if.operand_A !== 8'h00) begin n_fail++; $display("FAIL async_rst_a got %h want 00", rf_if.operand_A); end
        if (rf_if.flags !== 4'h0) begin n_fail++; $display("FAIL async_rst_flags got %h want 0", rf_if.flags); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests += 2;
        if (rf_if.operand_A !== 8'h00) begin n_fail++; $display("FAIL rst_no_commit_a got %h want 00", rf_if.operand_A); end
        if (rf_if.pc !== 16'h0100) begin n_fail++; $display("FAIL rst_no_commit_pc got %h want 0100", rf_if.pc); end
        @(posedge clk);
        model_commit();
        #1;
        n_tests += 3;
        if (rf_if.operand_A !== 8'h99) begin n_fail++; $display("FAIL first_write_a got %h want 99", rf_if.operand_A); end
        if (rf_if.pc !== 16'h1234) begin n_fail++; $display("FAIL first_write_pc got %h want 1234", rf_if.pc); end
        if (rf_if.flags !== 4'hF) begin n_fail++; $display("FAIL first_write_flags got %h want f", rf_if.flags); end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_latency();
        test_flags();
        test_idu_wrap();
        test_priority();
        test_random();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
